// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - requester/consumer bundle for the shared 8x8 multiplier
interface mul_share_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_p;
  logic [1:0]  rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin share of one 8x8 multiplier across 4 requesters, 2-stage pipe
module mul_share_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  mul_share_arbiter_if.slave   bus
);
  logic        r_s1_valid;
  logic [7:0]  r_s1_a;
  logic [7:0]  r_s1_b;
  logic [1:0]  r_s1_id;
  logic        r_s2_valid;
  logic [15:0] r_s2_p;
  logic [1:0]  r_s2_id;
  logic [1:0]  r_ptr;

  logic        w_s2_load;
  logic        w_s1_can_load;
  logic        w_found;
  logic [1:0]  w_win;
  logic        w_accept;
  logic [3:0]  w_ready;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [15:0] w_prod;

  assign w_s2_load     = r_s1_valid & (~r_s2_valid | bus.rsp_ready);
  assign w_s1_can_load = ~r_s1_valid | w_s2_load;

  // First valid requester at or after r_ptr, wrapping 3->0
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = r_ptr + k[1:0];
      if (!w_found && bus.req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  // rst gates ready so nothing is advertised while reset is held
  assign w_accept = w_found & w_s1_can_load & ~rst;

  always_comb begin
    w_ready = 4'b0000;
    if (w_accept) begin
      w_ready[w_win] = 1'b1;
    end
  end

  assign w_a    = bus.req_a[{w_win, 3'b000} +: 8];
  assign w_b    = bus.req_b[{w_win, 3'b000} +: 8];
  assign w_prod = 16'(r_s1_a) * 16'(r_s1_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= 8'd0;
      r_s1_b     <= 8'd0;
      r_s1_id    <= 2'd0;
      r_s2_valid <= 1'b0;
      r_s2_p     <= 16'd0;
      r_s2_id    <= 2'd0;
      r_ptr      <= 2'd0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= w_a;
        r_s1_b     <= w_b;
        r_s1_id    <= w_win;
        r_ptr      <= w_win + 2'd1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_p     <= w_prod;
        r_s2_id    <= r_s1_id;
      end else if (bus.rsp_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_s2_valid;
  assign bus.rsp_p     = r_s2_p;
  assign bus.rsp_id    = r_s2_id;
endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 No parameters; requester count fixed at 4, operand width fixed at 8, product width fixed at 16.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  4  bit i = requester i presents an operand pair.
REQ-005 req_a  input  32  packed operand A, requester i at bits [8i+7:8i], unsigned.
REQ-006 req_b  input  32  packed operand B, same packing as req_a, unsigned.
REQ-007 req_ready  output  4  one-hot-or-zero; bit i = requester i's pair accepted this cycle.
REQ-008 rsp_valid  output  1  result held on rsp_p/rsp_id.
REQ-009 rsp_ready  input  1  consumer takes result this cycle.
REQ-010 rsp_p  output  16  unsigned product req_a*req_b of the accepted pair.
REQ-011 rsp_id  output  2  index of the requester that issued the pair.

Function
REQ-012 Block shares one internal unsigned 8x8 combinational multiplier among 4 requesters; it sequences it through a 2-stage pipeline: S1 (operands+id register), S2 (product+id register driving rsp_*).
REQ-013 Transfer on an input occurs when req_valid[i] & req_ready[i]; on the output when rsp_valid & rsp_ready.
REQ-014 S2 advance: s2_load = s1_valid & (~s2_valid | rsp_ready); S2 holds rsp_p/rsp_id stable while rsp_valid & ~rsp_ready.
REQ-015 S1 advance: s1_can_load = ~s1_valid | s2_load; a granted pair is accepted only when s1_can_load.
REQ-016 Arbitration: round-robin over req_valid starting at pointer ptr[1:0]; the first valid index at or after ptr (wrapping 3->0) wins.
REQ-017 req_ready[i] = (i is winner) & s1_can_load; req_ready is combinational from req_valid, ptr and pipeline state; at most one bit high.
REQ-018 On an accept from requester i, ptr <= (i+1) mod 4; with no accept, ptr holds.
REQ-019 Requesters shall not make req_valid depend on req_ready; a requester not granted holds valid and operands until accepted.
REQ-020 Latency: pair accepted in cycle N appears on rsp_* at N+2 when no backpressure; throughput 1 result/cycle with rsp_ready held high.
REQ-021 Product full 16-bit, no truncation; 255*255 = 16'hFE01; any operand 0 gives 0.
REQ-022 Results emerge in acceptance order; none dropped or duplicated under any rsp_ready pattern.
REQ-023 Simultaneous S2 drain and S1 load in one cycle is legal and shall not create a bubble.
REQ-024 With S1 and S2 both full and rsp_ready low, req_ready = 0.
REQ-025 No req_valid: pipeline drains normally, ptr unchanged.

Reset
REQ-026 While rst high: s1_valid = 0, s2_valid = 0, ptr = 0, rsp_valid = 0, rsp_p = 16'h0000, rsp_id = 2'b00, req_ready = 4'b0000.
REQ-027 Reset asserted mid-operation discards all in-flight pairs immediately; no result for them is ever produced.
REQ-028 After rst deasserts, requester 0 has highest priority on the first arbitration.

Verification
REQ-029 Single: rst release, req_valid=4'b0100, a2=8'd13, b2=8'd11, rsp_ready=1 -> req_ready=4'b0100 one cycle, 2 cycles later rsp_valid=1, rsp_p=16'd143, rsp_id=2.
REQ-030 Fairness: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, rsp_id sequence matches, each rsp_p correct.
REQ-031 Backpressure: all valid, rsp_ready=0 for 5 cycles -> exactly 2 accepts then req_ready=0, rsp_p/rsp_id stable; rsp_ready=1 -> results in order, no loss.
REQ-032 Boundary operands: (255,255)->16'hFE01, (0,200)->0, (1,255)->255, (128,2)->256.
REQ-033 Reset mid-flight: 2 pairs in pipeline, pulse rst asynchronously between edges -> rsp_valid drops immediately, no stale result after release, next grant to requester 0.
REQ-034 Random: random req_valid/operands/rsp_ready for 10k cycles vs. scoreboard queue -> every accepted pair yields exactly one correct result in order, no requester starved more than 3 accepts.
